// File: rtl/mc_residual.sv
// rtl/mc_residual.sv - motion-compensation residual stage: fetch prediction/current rows, emit current-prediction rows
// Reads are credit-limited so that the in-flight read plus the 2-entry output FIFO never exceed two rows.
module mc_residual #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int MV_MAX     = SEARCH_DIM - MACRO_DIM,
  localparam int IW        = $clog2(MACRO_DIM),
  localparam int RW        = MACRO_DIM * 8,
  localparam int OW        = MACRO_DIM * 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          validi,
  output logic          readyi,
  input  logic [5:0]    mv_x,
  input  logic [5:0]    mv_y,
  input  logic [15:0]   min_sad,
  output logic          rd_en,
  output logic [5:0]    ref_row,
  output logic [5:0]    ref_col,
  output logic [IW-1:0] cur_addr,
  input  logic [RW-1:0] ref_row_in,
  input  logic [RW-1:0] cur_row_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [OW-1:0] res_row,
  output logic [IW-1:0] res_idx,
  output logic          res_last,
  output logic [5:0]    mv_x_o,
  output logic [5:0]    mv_y_o,
  output logic [15:0]   sad_o,
  output logic          mv_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [IW-1:0] LAST = IW'(MACRO_DIM - 1);
  localparam logic [5:0]    MV_LIM = 6'(MV_MAX);

  state_t          state_q, state_d;
  logic [IW-1:0]   r_q, r_d;
  logic [IW-1:0]   iss_idx_q, iss_idx_d;
  logic            inflight_q, inflight_d;
  logic [5:0]      mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic [15:0]     sad_q, sad_d;
  logic            err_q, err_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [OW-1:0]   e0_row_q, e0_row_d, e1_row_q, e1_row_d;
  logic [IW-1:0]   e0_idx_q, e0_idx_d, e1_idx_q, e1_idx_d;
  logic            e0_last_q, e0_last_d, e1_last_q, e1_last_d;

  logic            pop, push, can_issue, rd_en_c;
  logic [2:0]      occ;
  logic [OW-1:0]   new_row;
  logic            new_last;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    iss_idx_d  = iss_idx_q;
    mv_x_d     = mv_x_q;
    mv_y_d     = mv_y_q;
    sad_d      = sad_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    e0_row_d   = e0_row_q;
    e0_idx_d   = e0_idx_q;
    e0_last_d  = e0_last_q;
    e1_row_d   = e1_row_q;
    e1_idx_d   = e1_idx_q;
    e1_last_d  = e1_last_q;
    rd_en_c    = 1'b0;
    new_row    = '0;

    for (int c = 0; c < MACRO_DIM; c++) begin
      new_row[9*c +: 9] = {1'b0, cur_row_in[8*c +: 8]} - {1'b0, ref_row_in[8*c +: 8]};
    end
    new_last  = (iss_idx_q == LAST);
    push      = inflight_q;
    pop       = (cnt_q != 2'd0) && res_ready;
    occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    can_issue = (occ < 3'd2);

    // Shift-register FIFO: entry 0 is always the registered head.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          e0_row_d = new_row; e0_idx_d = iss_idx_q; e0_last_d = new_last;
        end else begin
          e1_row_d = new_row; e1_idx_d = iss_idx_q; e1_last_d = new_last;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_row_d = e1_row_q; e0_idx_d = e1_idx_q; e0_last_d = e1_last_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_row_d = new_row; e0_idx_d = iss_idx_q; e0_last_d = new_last;
        end else begin
          e0_row_d = e1_row_q; e0_idx_d = e1_idx_q; e0_last_d = e1_last_q;
          e1_row_d = new_row; e1_idx_d = iss_idx_q; e1_last_d = new_last;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (validi) begin
          mv_x_d  = (mv_x > MV_LIM) ? MV_LIM : mv_x;
          mv_y_d  = (mv_y > MV_LIM) ? MV_LIM : mv_y;
          err_d   = (mv_x > MV_LIM) || (mv_y > MV_LIM);
          sad_d   = min_sad;
          r_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (can_issue) begin
          rd_en_c   = 1'b1;
          iss_idx_d = r_q;
          r_d       = r_q + 1'b1;
          if (r_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == 2'd0 && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    inflight_d = rd_en_c;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      iss_idx_q  <= '0;
      inflight_q <= 1'b0;
      mv_x_q     <= '0;
      mv_y_q     <= '0;
      sad_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      e0_row_q   <= '0;
      e0_idx_q   <= '0;
      e0_last_q  <= 1'b0;
      e1_row_q   <= '0;
      e1_idx_q   <= '0;
      e1_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      iss_idx_q  <= iss_idx_d;
      inflight_q <= inflight_d;
      mv_x_q     <= mv_x_d;
      mv_y_q     <= mv_y_d;
      sad_q      <= sad_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      e0_row_q   <= e0_row_d;
      e0_idx_q   <= e0_idx_d;
      e0_last_q  <= e0_last_d;
      e1_row_q   <= e1_row_d;
      e1_idx_q   <= e1_idx_d;
      e1_last_q  <= e1_last_d;
    end
  end

  assign readyi    = (state_q == IDLE);
  assign rd_en     = rd_en_c;
  assign ref_row   = mv_y_q + 6'(r_q);
  assign ref_col   = mv_x_q;
  assign cur_addr  = r_q;
  assign res_valid = (cnt_q != 2'd0);
  assign res_row   = e0_row_q;
  assign res_idx   = e0_idx_q;
  assign res_last  = e0_last_q;
  assign mv_x_o    = mv_x_q;
  assign mv_y_o    = mv_y_q;
  assign sad_o     = sad_q;
  assign mv_err    = err_q;

endmodule

// File: doc/mc_residual.md
Name: mc_residual

Overview:
- Motion-compensation and residual stage directly downstream of the motion estimator (me).
- Accepts one motion vector plus SAD result per macroblock over a valid/ready handshake.
- Fetches the matching MACRO_DIM x MACRO_DIM prediction block from the search-window RAM and the current macroblock from the current-picture RAM.
- Emits one row of signed residuals (current - prediction) per cycle to the transform stage, with backpressure.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search-window edge in pixels.
- MV_MAX, SEARCH_DIM-MACRO_DIM (32), largest legal mv_x/mv_y.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high.
- validi  in  1  mv/sad valid from me.
- readyi  out  1  ready to accept mv/sad.
- mv_x  in  6  horizontal offset of best match in window.
- mv_y  in  6  vertical offset of best match in window.
- min_sad  in  16  best SAD.
- rd_en  out  1  read strobe to both RAMs.
- ref_row  out  6  search-window row address.
- ref_col  out  6  search-window start column. The memory wrapper returns MACRO_DIM consecutive pixels.
- cur_addr  out  $clog2(MACRO_DIM)  current-picture row address.
- ref_row_in  in  MACRO_DIM*8  prediction row, valid 1 cycle after rd_en.
- cur_row_in  in  MACRO_DIM*8  current row, valid 1 cycle after rd_en.
- res_valid  out  1  residual row valid.
- res_ready  in  1  downstream ready.
- res_row  out  MACRO_DIM*9  signed residuals; element c at bits [9c+8:9c].
- res_idx  out  $clog2(MACRO_DIM)  row index of res_row.
- res_last  out  1  res_row is the final row of the block.
- mv_x_o, mv_y_o  out  6 each  latched (clamped) vector.
- sad_o  out  16  latched SAD.
- mv_err  out  1  input vector was out of range and was clamped.

Behaviour:
- Reset (rst_n=1 at a clk edge): state IDLE; FIFO and in-flight flag cleared; readyi=1.
  - All other outputs 0: rd_en, res_valid, res_row, res_idx, res_last, mv_x_o, mv_y_o, sad_o, mv_err.
  - Reset mid-block aborts the block. RAM data returning in the following cycle is discarded.
- FSM: IDLE -> FETCH -> DRAIN -> IDLE.
  - IDLE: readyi=1. On validi&readyi, latch the vector and SAD, set row counter r=0, go to FETCH.
  - Clamping on latch: mv_x_o=min(mv_x,MV_MAX), mv_y_o=min(mv_y,MV_MAX), mv_err=(mv_x>MV_MAX)|(mv_y>MV_MAX).
  - FETCH: readyi=0. rd_en asserted when credit allows, with ref_row=mv_y_o+r, ref_col=mv_x_o, cur_addr=r. r increments on each issue. After issuing r=MACRO_DIM-1, go to DRAIN.
  - DRAIN: readyi=0. When FIFO is empty, no read is in flight, and the last row is accepted, go to IDLE.
  - mv_x_o/mv_y_o/sad_o/mv_err stay stable from accept until the next accept.
- Credit rule: 2-entry output FIFO plus 1-bit in-flight flag. rd_en=1 only if (occupancy + inflight - pop) < 2, where pop=res_valid&res_ready. Rows are never dropped or duplicated.
- Datapath: in the cycle after rd_en, res[c] = {1'b0,cur[c]} - {1'b0,ref[c]}, 9-bit two's complement, range -255..+255, no saturation. res_idx and res_last (idx==MACRO_DIM-1) are pushed into the FIFO with the row.
- Output side: res_valid = FIFO non-empty; FIFO head is registered. While res_valid&!res_ready, res_row/res_idx/res_last hold stable.
- Latency: accept in cycle T -> rd_en row 0 in T+1 -> res_valid row 0 in T+3.
- Throughput: with res_ready held at 1, one row per cycle; 16 consecutive rows.
- Back-to-back: the next block is accepted the cycle after return to IDLE. readyi is never high while a block is active.

Test Plan:
- mv=(0,0), window pixel=(row+col)&0xFF, cur all 0x80, res_ready=1, accept at T -> rows 0..15 in cycles T+3..T+18; element c of row r = 0x80-(r+c); res_last only on idx 15.
- mv=(32,32), same window -> ref_row 32..47, ref_col=32; element = 0x80-(r+c+64) as 9-bit signed (row 0 col 0 = 9'h040); mv_err=0.
- mv_x=40, mv_y=5 -> mv_x_o=32, mv_y_o=5, mv_err=1 held until next accept; data fetched from col 32.
- cur all 0x00 with ref all 0xFF -> every element 9'h101 (-255); swapped -> 9'h0FF (+255).
- res_ready high 1 of every 3 cycles -> idx order 0..15, no gaps or repeats, res_row stable when stalled, rd_en never raises occupancy+inflight above 2.
- Assert rst_n during row 7 output -> next cycle res_valid=0, readyi=1, all outputs 0; new block with mv=(1,2) produces clean rows 0..15.
